// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and helpers for the iterative NTT engine
package ntt_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, TWID, BFLY, OUT} state_t;

    localparam int MAX_LG = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (v > (1 << i)) r = i + 1;
        end
        return r;
    endfunction

    // Reverses the low lg bits of v; bits at and above lg come back as zero.
    function automatic logic [MAX_LG-1:0] bitrev(input logic [MAX_LG-1:0] v, input int lg);
        logic [MAX_LG-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_LG; k++) begin
            if (k < lg) r[k] = v[lg-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_if.sv
// rtl/ntt_if.sv - control, load and result streams of the NTT engine
interface ntt_if #(
    parameter int W = 12
);
    logic         start;
    logic         inv;
    logic [W-1:0] q;
    logic [W-1:0] w;
    logic [W-1:0] n_inv;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output start, inv, q, w, n_inv, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  start, inv, q, w, n_inv, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ntt_iter_mod_mul.sv
// rtl/ntt_iter_mod_mul.sv - combinational (a*b) mod q for a runtime modulus
module mod_mul #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    output logic [W-1:0] p
);
    always_comb begin
        p = W'(({W'(0), a} * {W'(0), b}) % {W'(0), q});
    end
endmodule

// File: rtl/ntt_iter.sv
// rtl/ntt_iter.sv - in-place radix-2 NTT, one butterfly per clock
module ntt_iter
    import ntt_pkg::*;
#(
    parameter int N = 128,
    parameter int W = 12
) (
    input  logic clk,
    input  logic rst,
    ntt_if.slave bus
);
    localparam int LG    = clog2(N);
    localparam int HN    = N / 2;
    localparam int TW_AW = LG - 1;

    state_t         state, state_nxt;
    logic [W-1:0]   q_r, w_r, ninv_r;
    logic           inv_r;
    logic [LG-1:0]  cnt;
    logic [LG-1:0]  st;
    logic [W-1:0]   mem [N];
    logic [W-1:0]   tw  [HN];

    logic [LG-1:0]    h, lo, sh, idx_i, idx_j, load_idx;
    logic [TW_AW-1:0] tw_idx, tw_prev;
    logic [W-1:0]     mul_a, mul_b, prod, scaled, in_red, bsum, bdif;
    logic [W:0]       sum_raw, dif_raw;

    always_comb begin
        h        = LG'(1) << st;
        lo       = cnt & (h - LG'(1));
        idx_i    = ((cnt >> st) << (st + LG'(1))) | lo;
        idx_j    = idx_i | h;
        sh       = LG'(LG - 1) - st;
        tw_idx   = TW_AW'(lo << sh);
        tw_prev  = TW_AW'(cnt - LG'(1));
        load_idx = LG'(bitrev(MAX_LG'(cnt), LG));
        in_red   = W'(bus.in_data % q_r);
    end

    // Twiddle generation and butterflies never overlap, so they share one multiplier.
    assign mul_a = (state == TWID) ? tw[tw_prev] : mem[idx_j];
    assign mul_b = (state == TWID) ? w_r : tw[tw_idx];

    mod_mul #(.W(W)) u_mul_core (.a(mul_a), .b(mul_b), .q(q_r), .p(prod));
    mod_mul #(.W(W)) u_mul_out  (.a(mem[cnt]), .b(ninv_r), .q(q_r), .p(scaled));

    always_comb begin
        sum_raw = {1'b0, mem[idx_i]} + {1'b0, prod};
        dif_raw = {1'b0, mem[idx_i]} + {1'b0, q_r} - {1'b0, prod};
        bsum    = (sum_raw >= {1'b0, q_r}) ? W'(sum_raw - {1'b0, q_r}) : W'(sum_raw);
        bdif    = (dif_raw >= {1'b0, q_r}) ? W'(dif_raw - {1'b0, q_r}) : W'(dif_raw);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: if (bus.in_valid && cnt == LG'(N - 1)) state_nxt = TWID;
            TWID: if (cnt == LG'(HN - 1)) state_nxt = BFLY;
            BFLY: if (cnt == LG'(HN - 1) && st == LG'(LG - 1)) state_nxt = OUT;
            OUT:  if (bus.out_ready && cnt == LG'(N - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            st     <= '0;
            q_r    <= '0;
            w_r    <= '0;
            ninv_r <= '0;
            inv_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    st  <= '0;
                    if (bus.start) begin
                        q_r    <= bus.q;
                        w_r    <= bus.w;
                        ninv_r <= bus.n_inv;
                        inv_r  <= bus.inv;
                    end
                end
                LOAD: if (bus.in_valid) cnt <= cnt + LG'(1);
                TWID: cnt <= (cnt == LG'(HN - 1)) ? '0 : cnt + LG'(1);
                BFLY: begin
                    if (cnt == LG'(HN - 1)) begin
                        cnt <= '0;
                        st  <= st + LG'(1);
                    end else begin
                        cnt <= cnt + LG'(1);
                    end
                end
                OUT:  if (bus.out_ready) cnt <= cnt + LG'(1);
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && bus.in_valid) mem[load_idx] <= in_red;
        if (state == TWID) tw[cnt[TW_AW-1:0]] <= (cnt == '0) ? W'(1) : prod;
        if (state == BFLY) begin
            mem[idx_i] <= bsum;
            mem[idx_j] <= bdif;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == OUT);
    assign bus.out_last  = (state == OUT) && (cnt == LG'(N - 1));
    assign bus.out_data  = (state == OUT) ? (inv_r ? scaled : mem[cnt]) : '0;

endmodule

// File: tb/tb_ntt_iter.sv
// tb/tb_ntt_iter.sv - self-checking bench for ntt_iter at N=4 and N=128
module tb_ntt_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;
    logic        start = 1'b0, inv = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [11:0] q = '0, w = '0, n_inv = '0, in_data = '0;

    always #5 clk = ~clk;

    ntt_if #(.W(12)) if4 ();
    ntt_if #(.W(12)) if128 ();

    ntt_iter #(.N(4),   .W(12)) u4   (.clk(clk), .rst(rst), .bus(if4.slave));
    ntt_iter #(.N(128), .W(12)) u128 (.clk(clk), .rst(rst), .bus(if128.slave));

    assign if4.start     = start & ~sel;
    assign if4.inv       = inv;
    assign if4.q         = q;
    assign if4.w         = w;
    assign if4.n_inv     = n_inv;
    assign if4.in_valid  = in_valid & ~sel;
    assign if4.in_data   = in_data;
    assign if4.out_ready = out_ready & ~sel;

    assign if128.start     = start & sel;
    assign if128.inv       = inv;
    assign if128.q         = q;
    assign if128.w         = w;
    assign if128.n_inv     = n_inv;
    assign if128.in_valid  = in_valid & sel;
    assign if128.in_data   = in_data;
    assign if128.out_ready = out_ready & sel;

    logic        d_busy, d_in_ready, d_out_valid, d_out_last;
    logic [11:0] d_out_data;
    assign d_busy      = sel ? if128.busy      : if4.busy;
    assign d_in_ready  = sel ? if128.in_ready  : if4.in_ready;
    assign d_out_valid = sel ? if128.out_valid : if4.out_valid;
    assign d_out_last  = sel ? if128.out_last  : if4.out_last;
    assign d_out_data  = sel ? if128.out_data  : if4.out_data;

    int          n_tests = 0, n_fail = 0;
    int          vec [128];
    int          exp_q [$];
    int          rx_count = 0;
    bit          stalled = 1'b0;
    logic [11:0] held = '0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int mulmod(input int a, input int b, input int m);
        return int'((longint'(a) * longint'(b)) % longint'(m));
    endfunction

    // Direct O(N^2) evaluation of X_k = sum a_j w^(jk) mod q.
    task automatic model(input bit iv, input int qq, input int ww, input int ni, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            int wk, p, acc;
            wk = 1;
            for (int e = 0; e < k; e++) wk = mulmod(wk, ww, qq);
            p = 1;
            acc = 0;
            for (int j = 0; j < n; j++) begin
                acc = (acc + mulmod(vec[j] % qq, p, qq)) % qq;
                p = mulmod(p, wk, qq);
            end
            if (iv) acc = mulmod(acc, ni, qq);
            exp_q.push_back(acc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else if (d_out_valid) begin
            if (stalled) check("stall_hold", d_out_data, held);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("out_data", d_out_data, exp_q[0]);
                    check("out_last", d_out_last, exp_q.size() == 1);
                    void'(exp_q.pop_front());
                end
                rx_count++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = d_out_data;
            end
        end else begin
            stalled = 1'b0;
            check("idle_data_zero", d_out_data, 0);
        end
    end

    task automatic do_start(input bit iv, input int qq, input int ww, input int ni);
        inv = iv;
        q = 12'(qq);
        w = 12'(ww);
        n_inv = 12'(ni);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("in_ready_after_start", d_in_ready, 1);
    endtask

    task automatic do_load(input int n, input bit gaps);
        for (int j = 0; j < n; j++) begin
            int tmo;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = 12'(vec[j]);
            tmo = 0;
            while (!d_in_ready && tmo < 100) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (tmo >= 100) check("load_timeout", tmo, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Starts one cycle after the last accept; optionally pokes start/q/w/inv/in_valid while busy.
    task automatic wait_valid(input int n, input bit poke);
        int cyc;
        logic [11:0] sq, sw;
        logic si;
        cyc = 1;
        out_ready = 1'b0;
        while (!d_out_valid && cyc < 3000) begin
            if (poke && cyc == 2) begin
                sq = q; sw = w; si = inv;
                start = 1'b1; q = 12'd11; w = 12'd3; inv = ~inv;
                in_valid = 1'b1; in_data = 12'd7;
                @(posedge clk); #1;
                start = 1'b0; q = sq; w = sw; inv = si; in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        check("first_valid_latency", cyc, n / 2 + (n / 2) * $clog2(n) + 1);
    endtask

    task automatic drain(input int n, input bit stall);
        int rx0, tmo;
        rx0 = rx_count;
        tmo = 0;
        while (rx_count - rx0 < n && tmo < 5000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            tmo++;
        end
        out_ready = 1'b0;
        check("beats_received", rx_count - rx0, n);
        check("busy_after_last", d_busy, 0);
        exp_q.delete();
    endtask

    task automatic run(input int n, input bit iv, input int qq, input int ww, input int ni,
                       input bit gaps, input bit stall, input bit poke);
        do_start(iv, qq, ww, ni);
        do_load(n, gaps);
        wait_valid(n, poke);
        drain(n, stall);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit [4];

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_in_ready", d_in_ready, 0);
            check("rst_out_valid", d_out_valid, 0);
            check("rst_out_data", d_out_data, 0);
            check("rst_out_last", d_out_last, 0);
            check("rst_busy", d_busy, 0);
        end
        sel = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
        model(1'b0, 17, 4, 0, 4);
        lit = '{10, 7, 15, 6};
        for (int k = 0; k < 4; k++) check("pin_fwd4", exp_q[k], lit[k]);
        run(4, 1'b0, 17, 4, 0, 1'b0, 1'b0, 1'b1);

        vec[0] = 10; vec[1] = 7; vec[2] = 15; vec[3] = 6;
        model(1'b1, 17, 13, 13, 4);
        lit = '{1, 2, 3, 4};
        for (int k = 0; k < 4; k++) check("pin_inv4", exp_q[k], lit[k]);
        run(4, 1'b1, 17, 13, 13, 1'b0, 1'b0, 1'b0);

        vec[0] = 18; vec[1] = 0; vec[2] = 0; vec[3] = 0;
        model(1'b0, 17, 4, 0, 4);
        for (int k = 0; k < 4; k++) check("pin_reduce", exp_q[k], 1);
        run(4, 1'b0, 17, 4, 0, 1'b0, 1'b0, 1'b0);

        vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
        model(1'b0, 17, 4, 0, 4);
        run(4, 1'b0, 17, 4, 0, 1'b1, 1'b1, 1'b0);

        exp_q.delete();
        do_start(1'b0, 17, 4, 0);
        do_load(4, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", d_busy, 0);
        check("rst_mid_out_valid", d_out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        vec[0] = 16; vec[1] = 0; vec[2] = 9; vec[3] = 3;
        model(1'b0, 17, 4, 0, 4);
        run(4, 1'b0, 17, 4, 0, 1'b0, 1'b1, 1'b1);

        sel = 1'b1;
        for (int j = 0; j < 128; j++) vec[j] = 0;
        vec[0] = 5;
        model(1'b0, 257, 9, 0, 128);
        for (int k = 0; k < 128; k++) check("pin_impulse", exp_q[k], 5);
        run(128, 1'b0, 257, 9, 0, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 128; j++) vec[j] = 5;
        model(1'b1, 257, 200, 255, 128);
        check("pin_roundtrip0", exp_q[0], 5);
        check("pin_roundtrip1", exp_q[1], 0);
        run(128, 1'b1, 257, 200, 255, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 128; j++) vec[j] = int'($urandom_range(0, 4095));
        model(1'b0, 257, 9, 0, 128);
        run(128, 1'b0, 257, 9, 0, 1'b1, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_iter.md
# ntt_iter

Sequential, parametrised number-theoretic transform engine. It replaces the fully combinational O(N²) NTT with an in-place radix-2 Cooley–Tukey datapath that performs one butterfly per clock. It accepts N coefficients over a ready/valid stream and computes the forward or inverse cyclic NTT mod a runtime q. It returns the N results in natural order over a second ready/valid stream. It sits between the coefficient source and the pointwise-multiply stage of the polynomial-multiplier pipeline.

## Interface
- N, 128, transform length; power of two, ≥ 4
- W, 12, coefficient and modulus width in bits
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  in IDLE, captures q, w, inv, n_inv and begins a transform; ignored when busy=1
- inv  in  1  0 = forward, 1 = inverse (output scaled by n_inv)
- q  in  W  modulus; odd, 3 ≤ q < 2^W
- w  in  W  primitive N-th root of unity mod q (pass w⁻¹ for inverse)
- n_inv  in  W  N⁻¹ mod q; used only when inv=1
- in_valid / in_ready  in / out  1  load handshake
- in_data  in  W  coefficient a_j, natural order j = 0..N-1
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  W  X_k, natural order k = 0..N-1
- out_last  out  1  high with out_valid on k = N-1
- busy  out  1  high in every state except IDLE

## Operation
- Result definition: X_k = Σ a_j·w^(jk) mod q. For inv=1, the result is additionally multiplied by n_inv.
- FSM: IDLE → LOAD → TWID → BFLY → OUT → IDLE.
- **IDLE**: on start=1, register q, w, inv and n_inv, then go to LOAD. Captured values stay fixed until the engine returns to IDLE.
- **LOAD**: in_ready=1. On each accepted beat j, write (in_data mod q) to mem[bitrev(j)]. After the N-th accept, go to TWID.
- **TWID**: fill tw[0..N/2-1] with tw[0]=1 and tw[k]=tw[k-1]·w mod q. This takes one entry per cycle, N/2 cycles in total.
- **BFLY**: stage s = 1..log2N, with h = 2^(s-1). Counter b = 0..N/2-1 gives:
  - i = (b/h)·2h + b%h
  - t = mem[i+h]·tw[(b%h)·N/(2h)] mod q
  - mem[i] ← (mem[i]+t) mod q
  - mem[i+h] ← (mem[i]−t+q) mod q
- Memory reads are combinational and writes happen at the clock edge. Butterflies within a stage touch disjoint indices, so there are no hazards. The first butterfly of stage s+1 sees the writes from stage s.
- **OUT**: present mem[k], or mem[k]·n_inv mod q when inv=1.
  - k advances only on out_valid & out_ready.
  - After the beat with out_last, go to IDLE.
- All products are 2W bits wide and reduced mod q. Sums are W+1 bits wide and reduced by a single conditional subtract.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, FSM=IDLE, counters=0. mem and tw are not cleared.
- Cycle after start: LOAD, so in_ready=1.
- From the cycle after the last load accept: TWID lasts N/2 cycles and BFLY lasts (N/2)·log2N cycles. out_valid then rises on the next cycle and stays high until the final transfer.
- in_valid is ignored whenever in_ready=0. out_data must not change while out_valid=1 and out_ready=0.
- out_data is driven to 0 whenever out_valid=0.
- rst mid-operation returns to IDLE on the next edge. Any partial transform is discarded.
- Back-to-back operation: start is accepted in the cycle after the final out transfer, i.e. the first IDLE cycle.

## Structure
- The shared package ntt_pkg holds:
  - the state enum (IDLE, LOAD, TWID, BFLY, OUT)
  - a bitrev function parametrised by log2N
  - a clog2 helper
- Sub-module mod_mul: combinational (a·b) mod q, with W-bit operands and a runtime q. It is instantiated once for butterflies and twiddle generation, which are time-multiplexed because their states are exclusive. A second instance handles output scaling.
- mem[N] and tw[N/2] are register arrays inside ntt_iter.

## Test plan
- N=4, q=17, w=4, inv=0, input 1,2,3,4 → output 10,7,15,6 with out_last on the 4th beat. The first out_valid arrives 2+2·2+1 cycles after the last accept.
- N=4, q=17, w=13, n_inv=13, inv=1, input 10,7,15,6 → output 1,2,3,4.
- N=128, q=257, w=9 (order 128), impulse a_0=5 with all others 0 → all 128 outputs equal 5. Round-trip through inv=1 with w=200 and n_inv=255 restores the impulse.
- Backpressure: toggle out_ready pseudo-randomly and insert in_valid gaps → identical data to the unstalled run; out_data is stable while stalled.
- Input reduction: N=4, q=17, inputs 18,0,0,0 → outputs 1,1,1,1.
- rst asserted during BFLY → next cycle busy=0 and out_valid=0. A fresh transform started afterwards gives correct results, and start pulses while busy have no effect.
